// File: rtl/apb_interface_2_pkg.sv
// rtl/apb_interface_2_pkg.sv - shared offsets, status bits, sync constants and helpers
package apb_interface_2_pkg;

    // Register offsets within the 64-byte block window
    localparam logic [5:0] OFF_CTRL = 6'h00;   // CONFIG on write, STATUS on read
    localparam logic [5:0] OFF_DATA = 6'h04;   // TX byte on write, RX byte on read
    localparam logic [5:0] OFF_CMD  = 6'h0C;

    localparam int CMD_START_BIT = 1;

    localparam int ST_BUSY      = 0;
    localparam int ST_RX_VALID  = 1;
    localparam int ST_TX_ACTIVE = 2;

    localparam logic [4:0] SYNC_HI = 5'h1F;
    localparam logic [8:0] SYNC_LO = 9'h1FF;

    typedef enum logic {
        XFER_IDLE,
        XFER_BUSY
    } xfer_state_e;

    // Transfer lasts 8 * div cycles; returns the terminal value of a down-counter
    function automatic logic [6:0] xfer_last_count(input logic [1:0] sck);
        case (sck)
            2'd0:    return 7'd15;
            2'd1:    return 7'd31;
            2'd2:    return 7'd63;
            default: return 7'd127;
        endcase
    endfunction

    function automatic logic sync_match(input logic [63:0] sr);
        return (sr[62:58] == SYNC_HI) && (sr[36:32] == SYNC_HI) && (sr[8:0] == SYNC_LO);
    endfunction

endpackage

// File: rtl/apb_interface_2_if.sv
// rtl/apb_interface_2_if.sv - APB bus bundle with master and slave views
interface apb_interface_2_if;
    logic        i_PSEL0;
    logic        i_PENABLE;
    logic        i_PWRITE;
    logic [15:0] i_PADDR;
    logic [7:0]  i_PWDATA;
    logic [7:0]  i_PRDATA;
    logic        PREADY;
    logic [7:0]  o_PWDATA;
    logic [7:0]  o_PRDATA;

    modport slave (
        input  i_PSEL0, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PRDATA,
        output PREADY, o_PWDATA, o_PRDATA
    );

    modport master (
        output i_PSEL0, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PRDATA,
        input  PREADY, o_PWDATA, o_PRDATA
    );
endinterface

// File: rtl/apb_interface_2_rf_sync_rx.sv
// rtl/apb_interface_2_rf_sync_rx.sv - RF pulse deserialiser, sync matcher and packet latch
module apb_interface_2_rf_sync_rx
    import apb_interface_2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_mode_i,
    input  logic       rfin_i,
    input  logic       sh_en_i,
    input  logic       rd_shift_i,
    output logic [7:0] rx_top_o,
    output logic       rx_valid_o,
    output logic       pkt_rec_o
);

    logic        flag_q;
    logic [63:0] sr_q;
    logic [63:0] sr_d;
    logic [63:0] rx_word_q;
    logic [2:0]  rd_cnt_q;
    logic        rx_valid_q;
    logic        pkt_rec_q;
    logic        match;

    // Candidate shift value; a pulse arriving with the strobe still counts as a 1
    always_comb begin
        sr_d  = {sr_q[62:0], flag_q | rfin_i};
        match = rx_mode_i & sh_en_i & sync_match(sr_d);
    end

    // Pulse catcher and shift register, parked at zero outside receive mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            sr_q   <= '0;
        end else if (!rx_mode_i) begin
            flag_q <= 1'b0;
            sr_q   <= '0;
        end else if (sh_en_i) begin
            flag_q <= 1'b0;
            sr_q   <= match ? 64'd0 : sr_d;
        end else begin
            flag_q <= flag_q | rfin_i;
        end
    end

    // Packet latch and byte unloading; a fresh packet wins over a same-cycle unload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_word_q  <= '0;
            rd_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            pkt_rec_q  <= 1'b0;
        end else begin
            pkt_rec_q <= match;
            if (match) begin
                rx_word_q  <= sr_d;
                rx_valid_q <= 1'b1;
                rd_cnt_q   <= '0;
            end else if (rd_shift_i) begin
                rx_word_q <= {rx_word_q[55:0], 8'h00};
                rd_cnt_q  <= rd_cnt_q + 3'd1;
                if (rd_cnt_q == 3'd7) begin
                    rx_valid_q <= 1'b0;
                end
            end
        end
    end

    assign rx_top_o   = rx_word_q[63:56];
    assign rx_valid_o = rx_valid_q;
    assign pkt_rec_o  = pkt_rec_q;

endmodule

// File: rtl/apb_interface_2.sv
// rtl/apb_interface_2.sv - APB slave front end for the four-channel byte transfer engine
module apb_interface_2
    import apb_interface_2_pkg::*;
(
    input  logic             i_PCLK,
    input  logic             i_PRESET,
    apb_interface_2_if.slave apb,
    input  logic [9:0]       i_BASE_ADDR,
    input  logic             rfin,
    input  logic             sh_en,
    input  logic             RX,
    output logic             o_WR0,
    output logic             o_WR1,
    output logic             o_WR2,
    output logic             o_WR3,
    output logic             o_DR0,
    output logic             o_DR1,
    output logic             o_DR2,
    output logic             o_DR3,
    output logic             pkt_rec,
    output logic             TX_OUT
);

    logic [5:0]  offset;
    logic        hit;
    logic        wr_acc;
    logic        rd_cycle;
    logic        start_go;
    logic        tx_load;
    logic        rd_shift;
    logic [7:0]  status;
    logic [7:0]  rd_data;

    xfer_state_e state_q;
    logic [6:0]  cnt_q;
    logic [1:0]  xfer_slave_q;
    logic        xfer_rx_q;
    logic [3:0]  wr_q;
    logic [3:0]  dr_q;
    logic [7:0]  rx_byte_q;

    logic [5:0]  config_q;
    logic [7:0]  tx_byte_q;
    logic [7:0]  pwdata_q;
    logic [7:0]  prdata_q;

    logic [7:0]  tx_sr_q;
    logic [2:0]  tx_cnt_q;
    logic        tx_active_q;
    logic        tx_out_q;

    logic [7:0]  rx_top;
    logic        rx_valid;

    // Address decode, access qualification and engine control strobes
    always_comb begin
        offset   = apb.i_PADDR[5:0];
        hit      = apb.i_PSEL0 & (apb.i_PADDR[15:6] == i_BASE_ADDR);
        wr_acc   = hit & apb.i_PENABLE & apb.i_PWRITE;
        rd_cycle = apb.i_PSEL0 & apb.i_PENABLE & ~apb.i_PWRITE;
        start_go = wr_acc & (offset == OFF_CMD) & apb.i_PWDATA[CMD_START_BIT]
                   & (state_q == XFER_IDLE);
        tx_load  = start_go & ~RX & (config_q[3:2] == 2'd3);
        rd_shift = (state_q == XFER_BUSY) & (cnt_q == 7'd0) & xfer_rx_q
                   & (xfer_slave_q == 2'd3);

        status               = '0;
        status[ST_BUSY]      = (state_q == XFER_BUSY);
        status[ST_RX_VALID]  = rx_valid;
        status[ST_TX_ACTIVE] = tx_active_q;

        case (offset)
            OFF_CTRL: rd_data = status;
            OFF_DATA: rd_data = rx_byte_q;
            default:  rd_data = 8'h00;
        endcase
    end

    // Register file writes and registered read data; misses read back as zero
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            config_q  <= '0;
            tx_byte_q <= '0;
            pwdata_q  <= '0;
            prdata_q  <= '0;
        end else begin
            if (wr_acc) begin
                pwdata_q <= apb.i_PWDATA;
                if (offset == OFF_CTRL) config_q  <= apb.i_PWDATA[5:0];
                if (offset == OFF_DATA) tx_byte_q <= apb.i_PWDATA;
            end
            if (rd_cycle) begin
                prdata_q <= hit ? rd_data : 8'h00;
            end
        end
    end

    // Transfer engine: slave and direction captured at start, busy for 8 * div cycles
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state_q      <= XFER_IDLE;
            cnt_q        <= '0;
            xfer_slave_q <= '0;
            xfer_rx_q    <= 1'b0;
            wr_q         <= '0;
            dr_q         <= '0;
            rx_byte_q    <= '0;
        end else begin
            wr_q <= '0;
            dr_q <= '0;
            case (state_q)
                XFER_IDLE: begin
                    if (start_go) begin
                        state_q      <= XFER_BUSY;
                        cnt_q        <= xfer_last_count(config_q[1:0]);
                        xfer_slave_q <= config_q[3:2];
                        xfer_rx_q    <= RX;
                        if (!RX) wr_q <= 4'b0001 << config_q[3:2];
                    end
                end
                XFER_BUSY: begin
                    if (cnt_q == 7'd0) begin
                        state_q <= XFER_IDLE;
                        if (xfer_rx_q) begin
                            dr_q      <= 4'b0001 << xfer_slave_q;
                            rx_byte_q <= (xfer_slave_q == 2'd3) ? rx_top : apb.i_PRDATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                default: state_q <= XFER_IDLE;
            endcase
        end
    end

    // Channel 3 TX serialiser, MSB first, one bit per strobe; last bit is held
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            tx_sr_q     <= '0;
            tx_cnt_q    <= '0;
            tx_active_q <= 1'b0;
            tx_out_q    <= 1'b0;
        end else if (tx_load) begin
            tx_sr_q     <= tx_byte_q;
            tx_cnt_q    <= '0;
            tx_active_q <= 1'b1;
        end else if (sh_en && tx_active_q) begin
            tx_out_q <= tx_sr_q[7];
            tx_sr_q  <= {tx_sr_q[6:0], 1'b0};
            tx_cnt_q <= tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd7) begin
                tx_active_q <= 1'b0;
            end
        end
    end

    apb_interface_2_rf_sync_rx u_rf_rx (
        .clk        (i_PCLK),
        .rst        (i_PRESET),
        .rx_mode_i  (RX),
        .rfin_i     (rfin),
        .sh_en_i    (sh_en),
        .rd_shift_i (rd_shift),
        .rx_top_o   (rx_top),
        .rx_valid_o (rx_valid),
        .pkt_rec_o  (pkt_rec)
    );

    assign apb.PREADY   = apb.i_PSEL0 & apb.i_PENABLE;
    assign apb.o_PWDATA = pwdata_q;
    assign apb.o_PRDATA = prdata_q;

    assign {o_WR3, o_WR2, o_WR1, o_WR0} = wr_q;
    assign {o_DR3, o_DR2, o_DR1, o_DR0} = dr_q;
    assign TX_OUT = tx_out_q;

endmodule

// File: tb/tb_apb_interface_2.sv
// tb/tb_apb_interface_2.sv - self-checking bench for apb_interface_2
module tb_apb_interface_2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_interface_2_if bus ();

    logic [9:0] base;
    logic rfin, sh_en, rx;
    logic wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3, pkt_rec, tx_out;

    apb_interface_2 dut (
        .i_PCLK      (clk),
        .i_PRESET    (rst),
        .apb         (bus),
        .i_BASE_ADDR (base),
        .rfin        (rfin),
        .sh_en       (sh_en),
        .RX          (rx),
        .o_WR0       (wr0),
        .o_WR1       (wr1),
        .o_WR2       (wr2),
        .o_WR3       (wr3),
        .o_DR0       (dr0),
        .o_DR1       (dr1),
        .o_DR2       (dr2),
        .o_DR3       (dr3),
        .pkt_rec     (pkt_rec),
        .TX_OUT      (tx_out)
    );

    int checks = 0;
    int failures = 0;

    int n_wr [4] = '{0, 0, 0, 0};
    int n_dr [4] = '{0, 0, 0, 0};
    int n_pkt = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_prdata;
        logic [7:0]  exp_pwdata;
    } vec_t;

    vec_t vecs [8];

    always @(negedge clk) begin
        if (wr0) n_wr[0]++;
        if (wr1) n_wr[1]++;
        if (wr2) n_wr[2]++;
        if (wr3) n_wr[3]++;
        if (dr0) n_dr[0]++;
        if (dr1) n_dr[1]++;
        if (dr2) n_dr[2]++;
        if (dr3) n_dr[3]++;
        if (pkt_rec) n_pkt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [26:0] all_outs();
        return {tx_out, pkt_rec, wr3, wr2, wr1, wr0, dr3, dr2, dr1, dr0,
                bus.PREADY, bus.o_PRDATA, bus.o_PWDATA};
    endfunction

    task automatic apb_xfer(input logic w, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.i_PSEL0 = 1'b1; bus.i_PENABLE = 1'b0; bus.i_PWRITE = w;
        bus.i_PADDR = a; bus.i_PWDATA = d;
        @(negedge clk);
        bus.i_PENABLE = 1'b1;
        #1 check("pready", bus.PREADY, 1'b1);
        @(negedge clk);
        bus.i_PSEL0 = 1'b0; bus.i_PENABLE = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk); sh_en = 1'b1;
        @(negedge clk); sh_en = 1'b0;
    endtask

    // One RF bit period (scaled to 20 PCLK); pulse early, or coincident with the strobe
    task automatic feed_bit(input logic b, input logic same);
        @(negedge clk); rfin = b & ~same;
        @(negedge clk); rfin = 1'b0;
        repeat (8) @(negedge clk);
        sh_en = 1'b1; rfin = b & same;
        @(negedge clk); sh_en = 1'b0; rfin = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    initial begin
        logic [63:0] pkt;
        logic [7:0]  txb;
        int snap, snap2, busy_cycles, exp_busy;

        bus.i_PSEL0 = 0; bus.i_PENABLE = 0; bus.i_PWRITE = 0;
        bus.i_PADDR = 0; bus.i_PWDATA = 0; bus.i_PRDATA = 8'h3C;
        base = 10'd1; rfin = 0; sh_en = 0; rx = 0;

        vecs[0] = '{1'b0, 16'h0040, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 16'h0048, 8'h33, 8'h00, 8'h33};
        vecs[2] = '{1'b0, 16'h0048, 8'h00, 8'h00, 8'h33};
        vecs[3] = '{1'b1, 16'h0080, 8'h77, 8'h00, 8'h33};
        vecs[4] = '{1'b1, 16'h0044, 8'h5A, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 16'h0044, 8'h00, 8'h00, 8'h5A};
        vecs[6] = '{1'b0, 16'h004C, 8'h00, 8'h00, 8'h5A};
        vecs[7] = '{1'b1, 16'h0040, 8'h0F, 8'h00, 8'h0F};

        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 27'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outs", all_outs(), 27'd0);

        for (int i = 0; i < 8; i++) begin
            apb_xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_prdata", i), bus.o_PRDATA, vecs[i].exp_prdata);
            check($sformatf("vec%0d_pwdata", i), bus.o_PWDATA, vecs[i].exp_pwdata);
        end

        // TX on slave 3: CONFIG 0x0F already written by the table
        txb = 8'hA5;
        apb_xfer(1'b1, 16'h0044, txb);
        snap = n_wr[3];
        snap2 = n_wr[0] + n_wr[1] + n_wr[2];
        apb_xfer(1'b1, 16'h004C, 8'h02);
        for (int b = 7; b >= 0; b--) exp_q.push_back({7'd0, txb[b]});
        repeat (2) @(negedge clk);
        check("wr3_pulses", n_wr[3] - snap, 1);
        check("wr012_quiet", n_wr[0] + n_wr[1] + n_wr[2] - snap2, 0);
        apb_xfer(1'b0, 16'h0040, 8'h00);
        check("tx_active_set", bus.o_PRDATA[2], 1'b1);
        for (int i = 0; i < 8; i++) begin
            strobe();
            check($sformatf("tx_bit%0d", i), tx_out, exp_q.pop_front());
        end
        apb_xfer(1'b0, 16'h0040, 8'h00);
        check("tx_active_clr", bus.o_PRDATA[2], 1'b0);
        strobe();
        check("tx_hold", tx_out, txb[0]);
        repeat (140) @(negedge clk);
        apb_xfer(1'b0, 16'h0040, 8'h00);
        check("status_idle", bus.o_PRDATA, 8'h00);

        // Busy length with sck=01: continuous access phase reads STATUS every cycle
        apb_xfer(1'b1, 16'h0040, 8'h01);
        exp_busy = 8 * (2 << 1);
        snap = n_wr[0];
        busy_cycles = 0;
        @(negedge clk);
        bus.i_PSEL0 = 1; bus.i_PENABLE = 0; bus.i_PWRITE = 1;
        bus.i_PADDR = 16'h004C; bus.i_PWDATA = 8'h02;
        @(negedge clk); bus.i_PENABLE = 1;
        @(negedge clk); bus.i_PWRITE = 0; bus.i_PADDR = 16'h0040;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_PRDATA[0]) busy_cycles++;
        end
        bus.i_PSEL0 = 0; bus.i_PENABLE = 0;
        check("busy_cycles", busy_cycles, exp_busy);
        check("wr0_pulses", n_wr[0] - snap, 1);

        // Start while busy is ignored, later start after idle is honoured
        apb_xfer(1'b1, 16'h0040, 8'h05);
        snap = n_wr[1];
        apb_xfer(1'b1, 16'h004C, 8'h02);
        repeat (3) @(negedge clk);
        apb_xfer(1'b1, 16'h004C, 8'h02);
        repeat (50) @(negedge clk);
        check("start_busy_ignored", n_wr[1] - snap, 1);
        apb_xfer(1'b1, 16'h004C, 8'h02);
        repeat (50) @(negedge clk);
        check("start_after_idle", n_wr[1] - snap, 2);

        // RF receive: 9 leading zeros then the 64-bit packet; last bit pulse rides the strobe
        rx = 1'b1;
        pkt = 64'h7DD4EC5F595B51FF;
        snap = n_pkt;
        for (int i = 0; i < 9; i++) feed_bit(1'b0, 1'b0);
        for (int i = 63; i >= 1; i--) feed_bit(pkt[i], 1'b0);
        check("no_early_pkt", n_pkt - snap, 0);
        feed_bit(pkt[0], 1'b1);
        for (int i = 7; i >= 0; i--) exp_q.push_back(pkt[i*8 +: 8]);
        check("pkt_rec_pulses", n_pkt - snap, 1);
        apb_xfer(1'b0, 16'h0040, 8'h00);
        check("status_rx_valid", bus.o_PRDATA, 8'h02);

        // Unload 8 bytes through slave 3 with sck=00
        apb_xfer(1'b1, 16'h0040, 8'h0C);
        snap = n_dr[3];
        for (int i = 0; i < 8; i++) begin
            apb_xfer(1'b1, 16'h004C, 8'h02);
            repeat (20) @(negedge clk);
            apb_xfer(1'b0, 16'h0044, 8'h00);
            check($sformatf("rx_byte%0d", i), bus.o_PRDATA, exp_q.pop_front());
            if (i == 6) begin
                apb_xfer(1'b0, 16'h0040, 8'h00);
                check("rx_valid_before_last", bus.o_PRDATA[1], 1'b1);
            end
        end
        apb_xfer(1'b0, 16'h0084, 8'h00);
        check("miss_read_zero", bus.o_PRDATA, 8'h00);
        check("dr3_pulses", n_dr[3] - snap, 8);
        apb_xfer(1'b0, 16'h0040, 8'h00);
        check("status_after_unload", bus.o_PRDATA, 8'h00);
        apb_xfer(1'b1, 16'h00C4, 8'h99);
        check("miss_write_ignored", bus.o_PWDATA, 8'h02);

        // Slave 0 receive takes the external read byte
        apb_xfer(1'b1, 16'h0040, 8'h00);
        snap = n_dr[0];
        apb_xfer(1'b1, 16'h004C, 8'h02);
        repeat (20) @(negedge clk);
        apb_xfer(1'b0, 16'h0044, 8'h00);
        check("rx_ext_byte", bus.o_PRDATA, 8'h3C);
        check("dr0_pulses", n_dr[0] - snap, 1);

        // Asynchronous reset mid-transfer
        rx = 1'b0;
        apb_xfer(1'b1, 16'h0040, 8'h0F);
        apb_xfer(1'b1, 16'h0044, 8'hC3);
        apb_xfer(1'b1, 16'h004C, 8'h02);
        strobe();
        check("pre_reset_tx", tx_out, 1'b1);
        apb_xfer(1'b0, 16'h0040, 8'h00);
        check("pre_reset_status", bus.o_PRDATA, 8'h05);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outs", all_outs(), 27'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apb_xfer(1'b0, 16'h0040, 8'h00);
        check("post_reset_status", bus.o_PRDATA, 8'h00);
        apb_xfer(1'b0, 16'h0044, 8'h00);
        check("post_reset_rxbyte", bus.o_PRDATA, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_interface_2.md
Name: apb_interface_2

Overview:
- APB slave bridging the CPU bus to a byte-oriented transfer engine with four slave channels.
- Channel 3 serialises TX bytes onto TX_OUT, one bit per sh_en strobe.
- Channel 3 also deserialises pulse-coded RF input (rfin) into a 64-bit packet, flagging pkt_rec on sync match.
- Sits between the APB fabric and the RF front end; all state clocked by i_PCLK.

Parameters:
- SYNC_HI, 5'h1F, sync field value required at packet bits [62:58] and [36:32].
- SYNC_LO, 9'h1FF, sync field value required at packet bits [8:0].

Ports:
- i_PCLK  in  1  APB clock; sole clock.
- i_PRESET  in  1  reset, asynchronous, active-high.
- i_PSEL0  in  1  APB select.
- i_PENABLE  in  1  APB enable.
- i_PWRITE  in  1  1 = write.
- i_PADDR  in  16  address.
- i_PWDATA  in  8  write data.
- i_PRDATA  in  8  external read byte for slaves 0-2.
- i_BASE_ADDR  in  10  block base, compared with i_PADDR[15:6].
- rfin  in  1  RF pulse input.
- sh_en  in  1  bit strobe, PCLK-synchronous, 1 cycle wide.
- RX  in  1  1 = receive mode, 0 = transmit mode.
- o_WR0..o_WR3  out  1 each  write-issue pulse per slave.
- o_DR0..o_DR3  out  1 each  read-done pulse per slave.
- PREADY  out  1  APB ready.
- o_PWDATA  out  8  last accepted write data.
- o_PRDATA  out  8  APB read data.
- pkt_rec  out  1  packet-received pulse.
- TX_OUT  out  1  serial transmit bit.

Behaviour:
- Reset: all outputs 0; all registers 0.
- Decode: hit = i_PSEL0 & (i_PADDR[15:6] == i_BASE_ADDR).
- Access phase: hit & i_PENABLE. PREADY = i_PSEL0 & i_PENABLE (zero wait states).
- Writes, applied in the access cycle:
  - offset 0x00 CONFIG: [5:4] mode (stored, no external effect), [3:2] slave, [1:0] sck.
  - offset 0x04: TX byte.
  - offset 0x0C: CMD; bit1 = start (self-clearing). All other offsets ignored.
  - o_PWDATA latches i_PWDATA on every accepted write.
- Reads: o_PRDATA is registered in the access cycle; other offsets return 0.
  - offset 0x00 STATUS: [0] busy, [1] rx_valid, [2] tx_active, [7:3] = 0.
  - offset 0x04: RX byte.
- Start while busy is ignored. Otherwise busy = 1 for 8 × div PCLK cycles, with div = 2, 4, 8, 16 for sck 00, 01, 10, 11.
- Start with RX = 0:
  - o_WR[slave] pulses 1 cycle in the start cycle.
  - If slave = 3, TX byte loads tx_sr and tx_active = 1.
- Start with RX = 1, at end of transfer:
  - slave 3: RX byte = rx_word[63:56]; rx_word shifts left 8; rx_valid cleared after the 8th byte.
  - slaves 0-2: RX byte = i_PRDATA.
  - o_DR[slave] pulses 1 cycle.
- TX serialiser: on each sh_en while tx_active, TX_OUT <= tx_sr[7] and tx_sr shifts left. After 8 strobes tx_active = 0; TX_OUT holds the last bit until the next load.
- RF receive, only while RX = 1:
  - flag sets on any cycle with rfin = 1.
  - on sh_en: sr <= {sr[62:0], flag}, flag cleared. A pulse and a strobe in the same cycle shift in 1.
  - match check on the shifted value only: sr[62:58] == SYNC_HI, sr[36:32] == SYNC_HI, sr[8:0] == SYNC_LO.
  - on match: rx_word <= new sr, rx_valid = 1, pkt_rec pulses 1 cycle, sr cleared to 0.
- While RX = 0: flag and sr are held at 0.
- Simultaneous start and pkt_rec: the packet latch wins; a read in progress uses the old rx_word bytes already fetched.

Decomposition:
- Shared package: register offsets (0x00, 0x04, 0x0C), CMD start bit index, sck divider table, STATUS bit indices, SYNC_HI and SYNC_LO.
- One natural sub-module: rf_sync_rx (flag, 64-bit shift register, sync matcher, rx_word latch).

Test Plan:
- Reset then idle → all outputs 0. Read 0x40 with base 1 → o_PRDATA = 0x00.
- Write CONFIG 0x0F, TX 0xA5, CMD 0x02 with RX = 0 → o_WR3 single pulse. The next 8 sh_en produce TX_OUT = 1,0,1,0,0,1,0,1; STATUS[2] then 0.
- sck = 01, start → STATUS[0] = 1 for exactly 32 PCLK cycles.
- RX = 1, feed 10 + 5×1 + 21 + 5×1 + 23 + 9×1 bits (1 ms period, 100 ns rfin pulse, sh_en mid-period) → pkt_rec pulses on the final shift. rx_word equals the last 64 bits; STATUS[1] = 1.
- After packet 0x7DD4EC5F595B51FF: 8 × (start slave 3, read 0x44) → bytes 7D, D4, EC, 5F, 59, 5B, 51, FF. o_DR3 pulses 8 times; STATUS[1] = 0 after the last read.
- Address with i_PADDR[15:6] ≠ base → no register change, o_PRDATA = 0. Start while busy → ignored. Assert i_PRESET mid-transfer → all cleared immediately.
